// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the TinyRISC-V pipeline hazard sequencer.
// Holds the state encoding, default widths and the flush-window helper.
package pipe_hazard_ctrl_pkg;

    localparam int RV32_ADDR_WIDTH      = 32;
    localparam int PHC_FLUSH_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        PHC_IDLE  = 2'd0,
        PHC_FLUSH = 2'd1,
        PHC_DIV   = 2'd2
    } phc_state_e;

    // Cycles left in the flush window after the redirect cycle itself.
    function automatic logic [2:0] flush_remaining(input int unsigned cycles);
        logic [2:0] rem;
        if (cycles > 32'd1) begin
            rem = 3'(cycles - 32'd1);
        end else begin
            rem = 3'd0;
        end
        return rem;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_redirect_arb.sv
// Redirect arbiter: jump beats interrupt, and the winner selects the new PC.
// Purely combinational; callers gate the requests with pipeline state.
module redirect_arb
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = RV32_ADDR_WIDTH
) (
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              int_req,
    input  logic [ADDR_W-1:0] int_addr,
    output logic              redirect,
    output logic              take_int,
    output logic [ADDR_W-1:0] redirect_addr
);

    // Priority select of the redirect source and its target address.
    always_comb begin
        redirect      = 1'b0;
        take_int      = 1'b0;
        redirect_addr = '0;
        if (jump_req) begin
            redirect      = 1'b1;
            redirect_addr = jump_addr;
        end else if (int_req) begin
            redirect      = 1'b1;
            take_int      = 1'b1;
            redirect_addr = int_addr;
        end else begin
            redirect      = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 3-stage core: arbitrates redirects, keeps the
// multi-cycle flush window and divide stall, and inserts load-use bubbles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = PHC_FLUSH_CYCLES_DEF,
    parameter int ADDR_W       = RV32_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              int_req_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    input  logic              div_start_i,
    input  logic              div_done_i,
    input  logic              load_use_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              int_ack_o
);

    localparam logic [2:0] FLUSH_INIT = flush_remaining(FLUSH_CYCLES);

    phc_state_e        state_r;
    phc_state_e        state_next_s;
    logic [2:0]        cnt_r;
    logic [2:0]        cnt_next_s;
    logic              int_pend_r;
    logic              int_pend_next_s;

    logic              arb_jump_s;
    logic              arb_int_s;
    logic              arb_redirect_s;
    logic              arb_take_int_s;
    logic [ADDR_W-1:0] arb_addr_s;

    // Only IDLE accepts jumps; interrupts are taken in IDLE or when a divide completes.
    always_comb begin
        arb_jump_s = 1'b0;
        arb_int_s  = 1'b0;
        if (state_r == PHC_IDLE) begin
            arb_jump_s = jump_flag_i;
            arb_int_s  = int_req_i;
        end else if (state_r == PHC_DIV) begin
            arb_int_s  = div_done_i & (int_pend_r | int_req_i);
        end else begin
            arb_int_s  = 1'b0;
        end
    end

    redirect_arb #(
        .ADDR_W (ADDR_W)
    ) u_redirect_arb (
        .jump_req      (arb_jump_s),
        .jump_addr     (jump_addr_i),
        .int_req       (arb_int_s),
        .int_addr      (int_addr_i),
        .redirect      (arb_redirect_s),
        .take_int      (arb_take_int_s),
        .redirect_addr (arb_addr_s)
    );

    // Next-state and same-cycle pipeline controls; everything is forced low in reset.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        int_pend_next_s = int_pend_r;
        hold_pc_o       = 1'b0;
        hold_if_id_o    = 1'b0;
        hold_id_ex_o    = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        redirect_o      = 1'b0;
        redirect_addr_o = '0;
        int_ack_o       = 1'b0;
        if (!rst_n) begin
            state_next_s    = PHC_IDLE;
            cnt_next_s      = 3'd0;
            int_pend_next_s = 1'b0;
        end else begin
            case (state_r)
                PHC_IDLE: begin
                    if (arb_redirect_s) begin
                        redirect_o      = 1'b1;
                        redirect_addr_o = arb_addr_s;
                        int_ack_o       = arb_take_int_s;
                        flush_if_id_o   = 1'b1;
                        flush_id_ex_o   = 1'b1;
                        if (FLUSH_INIT != 3'd0) begin
                            state_next_s = PHC_FLUSH;
                            cnt_next_s   = FLUSH_INIT;
                        end else begin
                            state_next_s = PHC_IDLE;
                        end
                    end else if (div_start_i) begin
                        state_next_s = PHC_DIV;
                    end else if (load_use_i) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else begin
                        state_next_s = PHC_IDLE;
                    end
                end
                PHC_FLUSH: begin
                    // Events raised by instructions being flushed are dropped.
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    cnt_next_s    = cnt_r - 3'd1;
                    if (cnt_r <= 3'd1) begin
                        state_next_s = PHC_IDLE;
                        cnt_next_s   = 3'd0;
                    end else begin
                        state_next_s = PHC_FLUSH;
                    end
                end
                PHC_DIV: begin
                    if (div_done_i) begin
                        // A divide start in the done cycle is dropped: ID/EX was still held.
                        int_pend_next_s = 1'b0;
                        if (arb_redirect_s) begin
                            redirect_o      = 1'b1;
                            redirect_addr_o = arb_addr_s;
                            int_ack_o       = arb_take_int_s;
                            flush_if_id_o   = 1'b1;
                            flush_id_ex_o   = 1'b1;
                        end else begin
                            redirect_o      = 1'b0;
                        end
                        if (arb_redirect_s && (FLUSH_INIT != 3'd0)) begin
                            state_next_s = PHC_FLUSH;
                            cnt_next_s   = FLUSH_INIT;
                        end else begin
                            state_next_s = PHC_IDLE;
                        end
                    end else begin
                        hold_pc_o       = 1'b1;
                        hold_if_id_o    = 1'b1;
                        hold_id_ex_o    = 1'b1;
                        int_pend_next_s = int_pend_r | int_req_i;
                    end
                end
                default: begin
                    state_next_s    = PHC_IDLE;
                    cnt_next_s      = 3'd0;
                    int_pend_next_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, flush counter and pending-interrupt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= PHC_IDLE;
            cnt_r      <= 3'd0;
            int_pend_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            int_pend_r <= int_pend_next_s;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-level behavioural model checked
// every cycle, plus literal expectations for each scenario.
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          jump_flag, int_req, div_start, div_done, load_use;
    logic [AW-1:0] jump_addr, int_addr;
    logic          hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
    logic          redirect, int_ack;
    logic [AW-1:0] redirect_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // model: remaining forced-flush cycles, divide in flight, interrupt latched
    int   m_flush_left;
    bit   m_div;
    bit   m_pend;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .jump_flag_i     (jump_flag),
        .jump_addr_i     (jump_addr),
        .int_req_i       (int_req),
        .int_addr_i      (int_addr),
        .div_start_i     (div_start),
        .div_done_i      (div_done),
        .load_use_i      (load_use),
        .hold_pc_o       (hold_pc),
        .hold_if_id_o    (hold_if_id),
        .hold_id_ex_o    (hold_id_ex),
        .flush_if_id_o   (flush_if_id),
        .flush_id_ex_o   (flush_id_ex),
        .redirect_o      (redirect),
        .redirect_addr_o (redirect_addr),
        .int_ack_o       (int_ack)
    );

    // {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, redirect, int_ack}
    function automatic logic [6:0] outs();
        return {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, redirect, int_ack};
    endfunction

    task automatic chk(input string name, input logic [AW+6:0] got, input logic [AW+6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model step: compare DUT against the rules for this cycle, then advance.
    always @(negedge clk) begin
        logic [6:0]    e;
        logic [AW-1:0] ea;
        e  = 7'd0;
        ea = '0;
        if (!rst_n) begin
            m_flush_left = 0;
            m_div        = 1'b0;
            m_pend       = 1'b0;
        end else if (m_flush_left > 0) begin
            e = 7'b0001100;
            m_flush_left = m_flush_left - 1;
        end else if (m_div) begin
            if (div_done) begin
                if (m_pend || int_req) begin
                    e  = 7'b0001111;
                    ea = int_addr;
                    m_flush_left = FC - 1;
                end
                m_div  = 1'b0;
                m_pend = 1'b0;
            end else begin
                e = 7'b1110000;
                m_pend = m_pend | int_req;
            end
        end else if (jump_flag) begin
            e  = 7'b0001110;
            ea = jump_addr;
            m_flush_left = FC - 1;
        end else if (int_req) begin
            e  = 7'b0001111;
            ea = int_addr;
            m_flush_left = FC - 1;
        end else if (div_start) begin
            m_div = 1'b1;
        end else if (load_use) begin
            e = 7'b1100100;
        end
        chk("model", {outs(), redirect_addr}, {e, ea});
    end

    // Drive one cycle of inputs just after the clock edge, then settle before negedge+1.
    task automatic cyc(input logic jf, input logic [AW-1:0] ja, input logic ir,
                       input logic ds, input logic dd, input logic lu);
        @(posedge clk);
        #1;
        jump_flag = jf;
        jump_addr = ja;
        int_req   = ir;
        div_start = ds;
        div_done  = dd;
        load_use  = lu;
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [6:0] e, input logic [AW-1:0] ea);
        chk(name, {outs(), redirect_addr}, {e, ea});
    endtask

    localparam logic [AW-1:0] J = 32'h0000_0100;
    localparam logic [AW-1:0] Z = 32'h0000_0000;

    initial begin
        rst_n = 1'b0;
        jump_flag = 1'b1; jump_addr = J; int_req = 1'b1; int_addr = 32'h0000_0004;
        div_start = 1'b0; div_done = 1'b0; load_use = 1'b1;
        #13;
        lit("reset_outputs_low", 7'd0, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0);
            lit("idle_after_reset", 7'd0, Z);
        end
        // 2: jump with two flush cycles
        cyc(1'b1, J, 1'b0, 1'b0, 1'b0, 1'b0); lit("jump_redirect", 7'b0001110, J);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b1); lit("jump_flush2_ignores_lu", 7'b0001100, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("jump_flush_end", 7'd0, Z);
        // 3: jump beats int; int taken two cycles later
        cyc(1'b1, J, 1'b1, 1'b0, 1'b0, 1'b0); lit("jump_over_int", 7'b0001110, J);
        cyc(1'b0, Z, 1'b1, 1'b0, 1'b0, 1'b0); lit("int_ignored_in_flush", 7'b0001100, Z);
        cyc(1'b0, Z, 1'b1, 1'b0, 1'b0, 1'b0); lit("int_taken", 7'b0001111, 32'h0000_0004);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("int_flush_no_ack", 7'b0001100, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("int_done", 7'd0, Z);
        // 4: divide stall, jump ignored while busy
        cyc(1'b0, Z, 1'b0, 1'b1, 1'b0, 1'b0); lit("div_start_no_hold", 7'd0, Z);
        for (int i = 1; i <= 4; i++) begin
            cyc((i == 2), J, 1'b0, 1'b0, 1'b0, 1'b0);
            lit("div_holds", 7'b1110000, Z);
        end
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b1, 1'b0); lit("div_done_release", 7'd0, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("div_after", 7'd0, Z);
        // 5: interrupt pulsed mid-divide, taken at done
        cyc(1'b0, Z, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, Z, 1'b1, 1'b0, 1'b0, 1'b0); lit("div_int_no_ack", 7'b1110000, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("div_int_pending", 7'b1110000, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b1, 1'b0); lit("div_done_int", 7'b0001111, 32'h0000_0004);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("div_int_flush", 7'b0001100, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("div_int_idle", 7'd0, Z);
        // done with simultaneous start: start dropped
        cyc(1'b0, Z, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, Z, 1'b0, 1'b1, 1'b1, 1'b0); lit("done_with_start", 7'd0, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("no_back_to_back", 7'd0, Z);
        // 6: load-use bubble
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b1); lit("load_use_bubble", 7'b1100100, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("load_use_once", 7'd0, Z);
        // reset in DIV_BUSY with an interrupt latched
        cyc(1'b0, Z, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, Z, 1'b1, 1'b0, 1'b0, 1'b0); lit("pre_reset_hold", 7'b1110000, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        lit("async_reset_drops_holds", 7'd0, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b1, 1'b0); lit("pend_discarded", 7'd0, Z);
        cyc(1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0); lit("post_reset_idle", 7'd0, Z);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
